// File: rtl/mem_req_arbiter.sv
// Shares one SRAM-like memory port between the fetch and load/store requesters.
// One transaction is in flight at a time; responses are routed back to its owner.
module mem_req_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q,  last_d;
  logic              wr_q,    wr_d;
  logic [1:0]        size_q,  size_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic grant_inst, grant_data;
  logic in_idle, in_req, in_wait, resp_fire;

  // Data wins a tie unless it won the previous tie-capable grant, so fetch never starves.
  assign grant_data = data_req && !(inst_req && (last_q == OWN_DATA));
  assign grant_inst = inst_req && !grant_data;

  // Outputs are qualified with resetn so nothing leaks out while reset is held.
  assign in_idle   = resetn && (state_q == S_IDLE);
  assign in_req    = resetn && (state_q == S_REQ);
  assign in_wait   = resetn && (state_q == S_WAIT);
  assign resp_fire = in_wait && mem_data_ok;

  assign inst_addr_ok = in_idle && grant_inst;
  assign data_addr_ok = in_idle && grant_data;

  assign inst_data_ok = resp_fire && (owner_q == OWN_INST);
  assign data_data_ok = resp_fire && (owner_q == OWN_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

  assign mem_req   = in_req;
  assign mem_wr    = wr_q;
  assign mem_size  = size_q;
  assign mem_addr  = addr_q;
  assign mem_wstrb = wstrb_q;
  assign mem_wdata = wdata_q;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves a latch.
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (grant_data) begin
          state_d = S_REQ;
          owner_d = OWN_DATA;
          last_d  = OWN_DATA;
          wr_d    = data_wr;
          size_d  = data_size;
          addr_d  = data_addr;
          wstrb_d = data_wstrb;
          wdata_d = data_wdata;
        end else if (grant_inst) begin
          state_d = S_REQ;
          owner_d = OWN_INST;
          last_d  = OWN_INST;
          wr_d    = inst_wr;
          size_d  = inst_size;
          addr_d  = inst_addr;
          wstrb_d = inst_wstrb;
          wdata_d = inst_wdata;
        end
      end
      S_REQ:   if (mem_addr_ok) state_d = S_WAIT;
      S_WAIT:  if (mem_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    if (!resetn) begin
      state_q <= S_IDLE;
      owner_q <= OWN_INST;
      last_q  <= OWN_INST;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed self-checking bench for mem_req_arbiter: fetch, store, contention,
// backpressure, stray responses and reset during an outstanding transaction.
module tb_mem_req_arbiter;

  localparam bit W_INST = 1'b0;
  localparam bit W_DATA = 1'b1;

  typedef struct {
    bit          who;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int   total = 0;
  int   bad   = 0;
  txn_t sb[$];

  always #5 clk = ~clk;

  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the DUT captures them on the next rising edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic no_ack(input string tag);
    check({tag, ":inst_addr_ok"}, inst_addr_ok, 0);
    check({tag, ":data_addr_ok"}, data_addr_ok, 0);
    check({tag, ":inst_data_ok"}, inst_data_ok, 0);
    check({tag, ":data_data_ok"}, data_data_ok, 0);
  endtask

  task automatic push(input bit who);
    txn_t t;
    t.who   = who;
    t.wr    = (who == W_INST) ? inst_wr    : data_wr;
    t.size  = (who == W_INST) ? inst_size  : data_size;
    t.addr  = (who == W_INST) ? inst_addr  : data_addr;
    t.wstrb = (who == W_INST) ? inst_wstrb : data_wstrb;
    t.wdata = (who == W_INST) ? inst_wdata : data_wdata;
    sb.push_back(t);
  endtask

  // IDLE cycle with requests already driven: expect a grant pulse to 'who' only.
  task automatic grant(input string tag, input bit who);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    push(who);
    #1;
    check({tag, ":inst_addr_ok"}, inst_addr_ok, who == W_INST);
    check({tag, ":data_addr_ok"}, data_addr_ok, who == W_DATA);
    check({tag, ":grant_mem_req"}, mem_req, 0);
  endtask

  // REQ cycle: mem_* must present the oldest scoreboard entry.
  task automatic req_cycle(input string tag, input logic accept);
    mem_addr_ok = accept;
    mem_data_ok = 1'b0;
    #1;
    check({tag, ":sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      check({tag, ":mem_req"},   mem_req,   1);
      check({tag, ":mem_wr"},    mem_wr,    sb[0].wr);
      check({tag, ":mem_size"},  mem_size,  sb[0].size);
      check({tag, ":mem_addr"},  mem_addr,  sb[0].addr);
      check({tag, ":mem_wstrb"}, mem_wstrb, sb[0].wstrb);
      check({tag, ":mem_wdata"}, mem_wdata, sb[0].wdata);
    end
    check({tag, ":req_inst_addr_ok"}, inst_addr_ok, 0);
    check({tag, ":req_data_addr_ok"}, data_addr_ok, 0);
  endtask

  // WAIT cycle with a response: only the owner sees data_ok and the read data.
  task automatic resp(input string tag, input logic [31:0] rdata);
    txn_t t;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rdata;
    #1;
    check({tag, ":sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      t = sb.pop_front();
      check({tag, ":inst_data_ok"}, inst_data_ok, t.who == W_INST);
      check({tag, ":data_data_ok"}, data_data_ok, t.who == W_DATA);
      if (!t.wr) begin
        check({tag, ":inst_rdata"}, inst_rdata, (t.who == W_INST) ? rdata : 32'h0);
        check({tag, ":data_rdata"}, data_rdata, (t.who == W_DATA) ? rdata : 32'h0);
      end else begin
        check({tag, ":other_rdata"}, (t.who == W_INST) ? data_rdata : inst_rdata, 0);
      end
    end
    check({tag, ":resp_mem_req"}, mem_req, 0);
    check({tag, ":resp_inst_addr_ok"}, inst_addr_ok, 0);
    check({tag, ":resp_data_addr_ok"}, data_addr_ok, 0);
  endtask

  task automatic quiet(input string tag);
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    #1;
    no_ack(tag);
    check({tag, ":inst_rdata"}, inst_rdata, 0);
    check({tag, ":data_rdata"}, data_rdata, 0);
    check({tag, ":mem_req"}, mem_req, 0);
  endtask

  task automatic do_reset();
    cyc();
    resetn = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
    sb.delete();
  endtask

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wstrb = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;

    // Reset state
    cyc(); cyc();
    #1;
    no_ack("rst");
    check("rst:mem_req",   mem_req,   0);
    check("rst:mem_wr",    mem_wr,    0);
    check("rst:mem_size",  mem_size,  0);
    check("rst:mem_addr",  mem_addr,  0);
    check("rst:mem_wstrb", mem_wstrb, 0);
    check("rst:mem_wdata", mem_wdata, 0);
    resetn = 1'b1;

    // Single fetch
    cyc(); inst_req = 1; inst_wr = 0; inst_size = 2; inst_addr = 32'h1C00_0000;
    grant("fetch", W_INST);
    cyc(); inst_req = 0; req_cycle("fetch", 1'b1);
    cyc(); resp("fetch", 32'h0280_0C0C);
    cyc(); quiet("fetch_after");

    // Store from the data port
    cyc(); data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h1C00_00F3;
    data_wstrb = 4'b1000; data_wdata = 32'hABAB_ABAB;
    grant("store", W_DATA);
    cyc(); data_req = 0; req_cycle("store", 1'b1);
    check("store:mem_wr_literal", mem_wr, 1);
    check("store:mem_wstrb_literal", mem_wstrb, 4'b1000);
    cyc(); resp("store", 32'h1234_5678);
    cyc(); quiet("store_after");

    // Contention from reset: both held, expect DATA, INST, DATA, INST
    do_reset();
    inst_wr = 0; inst_size = 2; inst_addr = 32'h1C00_1000;
    data_wr = 0; data_size = 2; data_addr = 32'h8000_0010; data_wstrb = 0; data_wdata = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(); inst_req = 1; data_req = 1;
      grant($sformatf("cont%0d", i), (i % 2 == 0) ? W_DATA : W_INST);
      cyc(); req_cycle($sformatf("cont%0d", i), 1'b1);
      cyc(); resp($sformatf("cont%0d", i), 32'hC000_0000 + i);
    end
    cyc(); quiet("cont_after");

    // Backpressure: request fields must hold while mem_addr_ok is low
    cyc(); inst_req = 1; inst_addr = 32'h1C00_0100;
    grant("bp", W_INST);
    for (int i = 0; i < 5; i++) begin
      cyc(); inst_addr = 32'hDEAD_0000 + 32'(i);
      req_cycle($sformatf("bp_stall%0d", i), 1'b0);
    end
    cyc(); inst_req = 0; req_cycle("bp_accept", 1'b1);
    cyc(); resp("bp", 32'h5555_AAAA);
    cyc(); quiet("bp_after");

    // Stray mem_data_ok in IDLE and in REQ
    cyc(); mem_data_ok = 1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    no_ack("stray_idle");
    check("stray_idle:mem_req", mem_req, 0);
    cyc(); data_req = 1; data_wr = 0; data_addr = 32'h0000_0040;
    grant("stray", W_DATA);
    cyc(); data_req = 0; mem_data_ok = 1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    no_ack("stray_req");
    check("stray_req:mem_req", mem_req, 1);
    cyc(); req_cycle("stray_still_req", 1'b1);
    cyc(); resp("stray", 32'h0BAD_F00D);
    cyc(); quiet("stray_after");

    // Reset while waiting for the response
    cyc(); inst_req = 1; inst_addr = 32'h1C00_0200;
    grant("rstw", W_INST);
    cyc(); inst_req = 0; req_cycle("rstw", 1'b1);
    cyc(); resetn = 0; mem_addr_ok = 0; mem_data_ok = 0;
    #1;
    no_ack("rstw_low");
    check("rstw_low:mem_req", mem_req, 0);
    cyc(); resetn = 1; mem_data_ok = 1; mem_rdata = 32'h7777_7777;
    sb.delete();
    #1;
    no_ack("rstw_late_resp");
    check("rstw_late_resp:mem_req", mem_req, 0);
    check("rstw_late_resp:mem_addr", mem_addr, 0);
    cyc(); inst_req = 1; data_req = 1; inst_addr = 32'h1C00_0300; data_addr = 32'h8000_0300;
    grant("rstw_next", W_DATA);
    cyc(); data_req = 0; inst_req = 0; req_cycle("rstw_next", 1'b1);
    cyc(); resp("rstw_next", 32'h2468_ACE0);
    cyc(); quiet("rstw_next_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
